// File: rtl/mem_bus_ctrl_if.sv
// Request/response and external memory signals of the memory bus controller.
// The controller uses the slave view; the environment drives the master view.
interface mem_bus_ctrl_if;
  logic        rd_req;
  logic        wr_req;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  rd_req, wr_req, addr, wdata, mem_rdata, mem_ready,
    output rdata, busy, done, err, mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport master (
    output rd_req, wr_req, addr, wdata, mem_rdata, mem_ready,
    input  rdata, busy, done, err, mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: one read/write per transaction, strobes held for a minimum
// wait plus ready handshake, with timeout abort and registered done/err/rdata status.
module mem_bus_ctrl #(
  parameter int unsigned MIN_WAIT = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          reset,
  mem_bus_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [8:0] MIN_WAIT_C = 9'(MIN_WAIT);
  localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        complete;
  logic        timeout;

  always_comb begin
    // cnt_q >= MIN_WAIT, evaluated one bit wider so MIN_WAIT=0 is handled uniformly
    complete    = bus.mem_ready && ((9'(cnt_q) + 9'd1) > MIN_WAIT_C);
    timeout     = !complete && (cnt_q == CNT_LAST);
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.rd_req || bus.wr_req) begin
          mem_addr_d = bus.addr;
          is_wr_d    = bus.wr_req;
          if (bus.wr_req) begin
            mem_wdata_d = bus.wdata;
          end
          err_d   = 1'b0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (complete) begin
          if (!is_wr_q) begin
            rdata_d = bus.mem_rdata;
          end
          state_d = S_DONE;
        end else if (timeout) begin
          if (!is_wr_q) begin
            rdata_d = 16'hFFFF;
          end
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status and strobes are decoded from the next state so they come straight off flops
    busy_d   = (state_d == S_SETUP) || (state_d == S_ACCESS);
    done_d   = (state_d == S_DONE);
    mem_rd_d = (state_d == S_ACCESS) && !is_wr_d;
    mem_wr_d = (state_d == S_ACCESS) && is_wr_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized scoreboard bench for mem_bus_ctrl, plus a short directed run on a
// MIN_WAIT=0 instance for the minimum-latency path.
module tb_mem_bus_ctrl;
  localparam int MW = 2;
  localparam int TO = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_bus_ctrl_if bus ();
  mem_bus_ctrl_if bus0 ();

  mem_bus_ctrl #(.MIN_WAIT(MW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_bus_ctrl #(.MIN_WAIT(0), .TIMEOUT(4)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  typedef struct {
    int          req_cyc;
    int          lat;
    int          rd_strobes;
    int          wr_strobes;
    int          busy_cycles;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [15:0] model_rdata = '0;
  logic [15:0] model_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rdata"},     32'(bus.rdata),     32'd0);
    checkOutput({tag, "_busy"},      32'(bus.busy),      32'd0);
    checkOutput({tag, "_done"},      32'(bus.done),      32'd0);
    checkOutput({tag, "_err"},       32'(bus.err),       32'd0);
    checkOutput({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    checkOutput({tag, "_mem_rd"},    32'(bus.mem_rd),    32'd0);
    checkOutput({tag, "_mem_wr"},    32'(bus.mem_wr),    32'd0);
  endtask

  // op: 0 read, 1 write, 2 both (write wins); k: first ACCESS index with ready high
  task automatic applyStimulus(input int op, input int k);
    exp_t        e;
    int          m;
    int          hold;
    logic        is_wr;
    logic        timed_out;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] rv;
    a         = 16'($urandom);
    d         = 16'($urandom);
    rv        = 16'($urandom);
    is_wr     = (op != 0);
    hold      = $urandom_range(0, 2);
    m         = (k > MW) ? k : MW;
    timed_out = (m > TO - 1);
    if (timed_out) m = TO - 1;

    @(negedge clk);
    bus.addr      = a;
    bus.wdata     = d;
    bus.mem_rdata = rv;
    bus.rd_req    = (op != 1);
    bus.wr_req    = (op != 0);
    bus.mem_ready = 1'($urandom);

    if (is_wr) model_wdata = d;
    else       model_rdata = timed_out ? 16'hFFFF : rv;
    e.req_cyc     = cyc + 1;
    e.lat         = 2 + m;
    e.rd_strobes  = is_wr ? 0 : m + 1;
    e.wr_strobes  = is_wr ? m + 1 : 0;
    e.busy_cycles = m + 2;
    e.err         = timed_out;
    e.rdata       = model_rdata;
    e.mem_addr    = a;
    e.mem_wdata   = model_wdata;
    exp_q.push_back(e);

    for (int t = 0; t <= m + 2; t++) begin
      @(negedge clk);
      if (t >= hold) begin
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
      end
      if (t == 0) begin
        bus.addr  = 16'($urandom);
        bus.wdata = 16'($urandom);
      end
      if (t == 0 || t > m + 1) bus.mem_ready = 1'($urandom);
      else                     bus.mem_ready = ((t - 1) >= k);
    end
  endtask

  task automatic applyDut0(input int k);
    int   m;
    int   done_t;
    int   rd_n;
    logic to;
    to     = (k > 3);
    m      = to ? 3 : k;
    done_t = -1;
    rd_n   = 0;
    @(negedge clk);
    bus0.addr      = 16'h1234;
    bus0.mem_rdata = 16'hBEEF;
    bus0.rd_req    = 1'b1;
    bus0.mem_ready = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      bus0.rd_req = 1'b0;
      if (bus0.mem_rd) rd_n++;
      if (bus0.done && done_t < 0) done_t = t;
      bus0.mem_ready = (t >= 1) && ((t - 1) >= k);
    end
    checkOutput("mw0_done_latency", 32'(done_t),         32'(2 + m));
    checkOutput("mw0_rd_strobes",   32'(rd_n),           32'(m + 1));
    checkOutput("mw0_rdata",        32'(bus0.rdata),     to ? 32'hFFFF : 32'hBEEF);
    checkOutput("mw0_err",          32'(bus0.err),       32'(to));
    checkOutput("mw0_mem_addr",     32'(bus0.mem_addr),  32'h1234);
  endtask

  // Monitor: pops one expectation per done pulse
  initial begin : monitor
    int   rd_n;
    int   wr_n;
    int   busy_n;
    exp_t e;
    rd_n   = 0;
    wr_n   = 0;
    busy_n = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        rd_n   = 0;
        wr_n   = 0;
        busy_n = 0;
      end else begin
        if (bus.mem_rd) rd_n++;
        if (bus.mem_wr) wr_n++;
        if (bus.busy)   busy_n++;
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            checkOutput("spurious_done", 32'(bus.done), 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("done_latency", 32'(cyc - e.req_cyc), 32'(e.lat));
            checkOutput("rd_strobes",   32'(rd_n),            32'(e.rd_strobes));
            checkOutput("wr_strobes",   32'(wr_n),            32'(e.wr_strobes));
            checkOutput("busy_cycles",  32'(busy_n),          32'(e.busy_cycles));
            checkOutput("err",          32'(bus.err),         32'(e.err));
            checkOutput("rdata",        32'(bus.rdata),       32'(e.rdata));
            checkOutput("mem_addr",     32'(bus.mem_addr),    32'(e.mem_addr));
            checkOutput("mem_wdata",    32'(bus.mem_wdata),   32'(e.mem_wdata));
          end
          rd_n   = 0;
          wr_n   = 0;
          busy_n = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int r;
    int k;
    bus.rd_req     = 1'b0;
    bus.wr_req     = 1'b0;
    bus.addr       = '0;
    bus.wdata      = '0;
    bus.mem_rdata  = '0;
    bus.mem_ready  = 1'b0;
    bus0.rd_req    = 1'b0;
    bus0.wr_req    = 1'b0;
    bus0.addr      = '0;
    bus0.wdata     = '0;
    bus0.mem_rdata = '0;
    bus0.mem_ready = 1'b0;

    #12;
    checkAllZero("reset");
    @(negedge clk);
    #2 reset = 1'b1;

    applyStimulus(0, 0);
    applyStimulus(1, 0);
    applyStimulus(2, 1);
    applyStimulus(0, 255);
    applyStimulus(1, 255);
    applyStimulus(0, TO - 1);
    applyStimulus(0, TO);
    applyStimulus(2, 4);

    for (int i = 0; i < 36; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = $urandom_range(0, 9);
      case (r)
        6:       k = TO - 2 + $urandom_range(0, 1);
        7:       k = TO;
        8:       k = 255;
        9:       k = $urandom_range(0, 3);
        default: k = r;
      endcase
      applyStimulus($urandom_range(0, 2), k);
    end

    // Abort a read in ACCESS with reset, then run a clean read afterwards
    @(negedge clk);
    bus.addr      = 16'hC0DE;
    bus.rd_req    = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_reset_mem_rd", 32'(bus.mem_rd), 32'd1);
    #2 reset = 1'b0;
    #1 checkAllZero("async_reset");
    @(negedge clk);
    #2 reset = 1'b1;
    model_rdata = '0;
    model_wdata = '0;
    applyStimulus(0, 3);
    applyStimulus(1, 0);

    applyDut0(0);
    applyDut0(2);
    applyDut0(6);

    repeat (5) @(negedge clk);
    checkOutput("pending_expect", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
